// File: rtl/ks_multicycle_ctrl_if.sv
// Datapath/RAM control bundle driven by the K&S multi-cycle controller.
interface ks_multicycle_ctrl_if;
  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       write_reg_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       flags_reg_enable;
  logic       ram_write_enable;
  logic       halt;

  modport master (output branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
                  c_sel, operation, flags_reg_enable, ram_write_enable, halt);
  modport slave  (input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
                  c_sel, operation, flags_reg_enable, ram_write_enable, halt);
endinterface

// File: rtl/ks_multicycle_ctrl.sv
// K&S multi-cycle control FSM with configurable RAM wait states.
// Optional performance counters enabled by defining KS_CTRL_PERF_CNT_EN.
package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH,
    I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module ks_multicycle_ctrl
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  ks_multicycle_ctrl_if.master    ctl,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instr_count
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC_ALU, S_LOAD, S_STORE, S_BRANCH, S_HALTED
  } state_t;

  localparam logic [3:0] WLAST = 4'(MEM_WAIT);

  state_t     state, dec_next;
  logic [3:0] wcnt;
  logic [1:0] alu_op, dec_op;
  logic       alu_flags, dec_fl;
  logic       fetch_go, at_last, ovf;
  logic       br, pc, ir, wr, as, cs, fl, ram, hlt;
  logic [1:0] op;

  // run only gates the start of a fetch; an access in progress always finishes
  assign fetch_go = (wcnt != 4'd0) || run;
  assign at_last  = (wcnt == WLAST);
  assign ovf      = signed_overflow | unsigned_overflow;

  always_comb begin
    dec_next = S_FETCH;
    dec_op   = 2'b00;
    dec_fl   = 1'b0;
    case (decoded_instruction)
      I_ADD:    begin dec_next = S_EXEC_ALU; dec_op = 2'b01; dec_fl = 1'b1; end
      I_SUB:    begin dec_next = S_EXEC_ALU; dec_op = 2'b10; dec_fl = 1'b1; end
      I_AND:    begin dec_next = S_EXEC_ALU; dec_op = 2'b11; dec_fl = 1'b1; end
      I_OR:     begin dec_next = S_EXEC_ALU; dec_op = 2'b00; dec_fl = 1'b1; end
      I_MOVE:   dec_next = S_EXEC_ALU;
      I_LOAD:   dec_next = S_LOAD;
      I_STORE:  dec_next = S_STORE;
      I_HALT:   dec_next = S_HALTED;
      I_BRANCH: dec_next = S_BRANCH;
      I_BZERO:  if (zero_op)  dec_next = S_BRANCH;
      I_BNZERO: if (!zero_op) dec_next = S_BRANCH;
      I_BNEG:   if (neg_op)   dec_next = S_BRANCH;
      I_BNNEG:  if (!neg_op)  dec_next = S_BRANCH;
      I_BOV:    if (ovf)      dec_next = S_BRANCH;
      I_BNOV:   if (!ovf)     dec_next = S_BRANCH;
      default:  dec_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wcnt      <= 4'd0;
      alu_op    <= 2'b00;
      alu_flags <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (fetch_go) begin
          if (at_last) begin
            wcnt  <= 4'd0;
            state <= S_DECODE;
          end else wcnt <= wcnt + 4'd1;
        end
        S_DECODE: begin
          state     <= dec_next;
          alu_op    <= dec_op;
          alu_flags <= dec_fl;
        end
        S_LOAD: if (at_last) begin
          wcnt  <= 4'd0;
          state <= S_FETCH;
        end else wcnt <= wcnt + 4'd1;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Gating on rst keeps an aborted instruction from writing in the reset cycle
  always_comb begin
    {br, pc, ir, wr, as, cs, fl, ram, hlt} = '0;
    op = 2'b00;
    if (!rst) begin
      case (state)
        S_FETCH:    if (fetch_go && at_last) begin ir = 1'b1; pc = 1'b1; end
        S_EXEC_ALU: begin wr = 1'b1; op = alu_op; fl = alu_flags; end
        S_LOAD:     begin as = 1'b1; if (at_last) begin wr = 1'b1; cs = 1'b1; end end
        S_STORE:    begin as = 1'b1; ram = 1'b1; end
        S_BRANCH:   begin br = 1'b1; pc = 1'b1; end
        S_HALTED:   hlt = 1'b1;
        default:    ;
      endcase
    end
  end

  assign ctl.branch           = br;
  assign ctl.pc_enable        = pc;
  assign ctl.ir_enable        = ir;
  assign ctl.write_reg_enable = wr;
  assign ctl.addr_sel         = as;
  assign ctl.c_sel            = cs;
  assign ctl.operation        = op;
  assign ctl.flags_reg_enable = fl;
  assign ctl.ram_write_enable = ram;
  assign ctl.halt             = hlt;

`ifdef KS_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state != S_HALTED && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (ir && ins_q != '1)                ins_q <= ins_q + 1'b1;
    end
  end

  assign cycle_count = rst ? '0 : cyc_q;
  assign instr_count = rst ? '0 : ins_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif
endmodule

// File: tb/tb_ks_multicycle_ctrl.sv
// Bench for ks_multicycle_ctrl: one instance with MEM_WAIT=0, one with MEM_WAIT=2.
module tb_ks_multicycle_ctrl;
  import k_and_s_pkg::*;

  localparam int CW = 4;
`ifdef KS_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {branch, pc, ir, wr, addr_sel, c_sel, op[1:0], flags, ram_we, halt}
  localparam logic [10:0] O_HALT = 11'h001, O_RAM = 11'h002, O_FLG = 11'h004,
                          O_ADD  = 11'h008, O_SUB = 11'h010, O_AND = 11'h018,
                          O_CS   = 11'h020, O_AS  = 11'h040, O_WR  = 11'h080,
                          O_IR   = 11'h100, O_PC  = 11'h200, O_BR  = 11'h400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst [2];
  logic                    run [2];
  decoded_instruction_type di  [2];
  logic                    zf [2], nf [2], uo [2], so [2];
  logic [CW-1:0]           cyc [2], ins [2];

  ks_multicycle_ctrl_if cif0();
  ks_multicycle_ctrl_if cif1();

  ks_multicycle_ctrl #(.MEM_WAIT(0), .CNT_W(CW)) d0 (
    .clk(clk), .rst(rst[0]), .run(run[0]), .decoded_instruction(di[0]),
    .zero_op(zf[0]), .neg_op(nf[0]), .unsigned_overflow(uo[0]), .signed_overflow(so[0]),
    .ctl(cif0.master), .cycle_count(cyc[0]), .instr_count(ins[0]));

  ks_multicycle_ctrl #(.MEM_WAIT(2), .CNT_W(CW)) d1 (
    .clk(clk), .rst(rst[1]), .run(run[1]), .decoded_instruction(di[1]),
    .zero_op(zf[1]), .neg_op(nf[1]), .unsigned_overflow(uo[1]), .signed_overflow(so[1]),
    .ctl(cif1.master), .cycle_count(cyc[1]), .instr_count(ins[1]));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [10:0] obs(input int d);
    if (d == 0)
      return {cif0.branch, cif0.pc_enable, cif0.ir_enable, cif0.write_reg_enable,
              cif0.addr_sel, cif0.c_sel, cif0.operation, cif0.flags_reg_enable,
              cif0.ram_write_enable, cif0.halt};
    return {cif1.branch, cif1.pc_enable, cif1.ir_enable, cif1.write_reg_enable,
            cif1.addr_sel, cif1.c_sel, cif1.operation, cif1.flags_reg_enable,
            cif1.ram_write_enable, cif1.halt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // one clock: inputs already set, sample outputs at negedge, then advance past posedge
  task automatic expn(input int d, input string nm, input logic [10:0] e);
    @(negedge clk);
    chk(nm, obs(d), e);
    @(posedge clk); #1;
  endtask

  function automatic int sat(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  // Reference: expected output trace of one instruction from its first fetch cycle,
  // derived from the latency rules; dec marks the cycle the decoder inputs matter.
  typedef struct { logic [10:0] o; bit dec; } step_t;
  typedef step_t sq_t[$];

  function automatic sq_t build(input int w, input decoded_instruction_type in,
                                input logic z, input logic n, input logic u, input logic s);
    sq_t q;
    bit taken;
    for (int i = 0; i < w; i++) q.push_back('{11'h0, 1'b0});
    q.push_back('{O_IR | O_PC, 1'b0});
    q.push_back('{11'h0, 1'b1});
    taken = (in == I_BRANCH) || (in == I_BZERO && z) || (in == I_BNZERO && !z) ||
            (in == I_BNEG && n) || (in == I_BNNEG && !n) ||
            (in == I_BOV && (u || s)) || (in == I_BNOV && !(u || s));
    case (in)
      I_ADD:   q.push_back('{O_WR | O_ADD | O_FLG, 1'b0});
      I_SUB:   q.push_back('{O_WR | O_SUB | O_FLG, 1'b0});
      I_AND:   q.push_back('{O_WR | O_AND | O_FLG, 1'b0});
      I_OR:    q.push_back('{O_WR | O_FLG, 1'b0});
      I_MOVE:  q.push_back('{O_WR, 1'b0});
      I_STORE: q.push_back('{O_AS | O_RAM, 1'b0});
      I_LOAD: begin
        for (int i = 0; i < w; i++) q.push_back('{O_AS, 1'b0});
        q.push_back('{O_AS | O_WR | O_CS, 1'b0});
      end
      default: if (taken) q.push_back('{O_BR | O_PC, 1'b0});
    endcase
    return q;
  endfunction

  task automatic rand_phase(input int d, input int w, input int ncyc);
    sq_t q;
    decoded_instruction_type cur;
    logic cz, cn, cu, cs;
    bit halted, rn;
    int hcnt, cm, im;
    logic [10:0] e;
    cur = I_NOP; cz = 0; cn = 0; cu = 0; cs = 0;
    halted = 0; hcnt = 0; cm = 0; im = 0;
    rst[d] = 1'b1; run[d] = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < ncyc; c++) begin
      rn = ($urandom_range(0, 99) == 0) || (hcnt >= 8);
      run[d] = ($urandom_range(0, 3) != 0);
      di[d] = decoded_instruction_type'($urandom_range(0, 15));
      zf[d] = 1'($urandom); nf[d] = 1'($urandom);
      uo[d] = 1'($urandom); so[d] = 1'($urandom);
      if (!halted && q.size() == 0 && run[d] && !rn) begin
        cur = di[d]; cz = zf[d]; cn = nf[d]; cu = uo[d]; cs = so[d];
        q = build(w, cur, cz, cn, cu, cs);
      end else if (q.size() != 0 && q[0].dec) begin
        di[d] = cur; zf[d] = cz; nf[d] = cn; uo[d] = cu; so[d] = cs;
      end
      rst[d] = rn;
      @(negedge clk);
      e = rn ? 11'h0 : halted ? O_HALT : (q.size() != 0 ? q[0].o : 11'h0);
      chk($sformatf("rand_out%0d", d), obs(d), e);
      chk($sformatf("rand_cyc%0d", d), cyc[d], (PERF && !rn) ? cm : 0);
      chk($sformatf("rand_ins%0d", d), ins[d], (PERF && !rn) ? im : 0);
      @(posedge clk); #1;
      if (rn) begin
        q.delete(); halted = 0; hcnt = 0; cm = 0; im = 0;
      end else begin
        if (!halted) cm = sat(cm);
        if (e[8]) im = sat(im);
        if (halted) hcnt++;
        if (q.size() != 0) begin
          void'(q.pop_front());
          if (q.size() == 0 && cur == I_HALT) halted = 1;
        end
      end
    end
    rst[d] = 1'b1;
  endtask

  typedef struct {
    decoded_instruction_type in;
    logic z, n, u, s;
    int lat;
    logic [10:0] seen;
  } vec_t;

  vec_t tbl[$];
  logic [10:0] acc;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; run[d] = 1'b0; di[d] = I_NOP;
      zf[d] = 0; nf[d] = 0; uo[d] = 0; so[d] = 0;
    end
    @(posedge clk); #1;
    di[0] = I_ADD; di[1] = I_STORE; run[0] = 1'b1; run[1] = 1'b1;
    @(negedge clk);
    chk("rst_out0", obs(0), 0);
    chk("rst_out1", obs(1), 0);
    chk("rst_cnt0", {cyc[0], ins[0]}, 0);
    @(posedge clk); #1;

    // table-driven: MEM_WAIT=0, OR of outputs over the instruction, and its length
    tbl = '{
      '{I_ADD,    0,0,0,0, 3, O_IR|O_PC|O_WR|O_ADD|O_FLG},
      '{I_SUB,    0,0,0,0, 3, O_IR|O_PC|O_WR|O_SUB|O_FLG},
      '{I_AND,    0,0,0,0, 3, O_IR|O_PC|O_WR|O_AND|O_FLG},
      '{I_OR,     0,0,0,0, 3, O_IR|O_PC|O_WR|O_FLG},
      '{I_MOVE,   0,0,0,0, 3, O_IR|O_PC|O_WR},
      '{I_LOAD,   0,0,0,0, 3, O_IR|O_PC|O_AS|O_WR|O_CS},
      '{I_STORE,  0,0,0,0, 3, O_IR|O_PC|O_AS|O_RAM},
      '{I_BRANCH, 0,0,0,0, 3, O_IR|O_PC|O_BR},
      '{I_BZERO,  1,0,0,0, 3, O_IR|O_PC|O_BR},
      '{I_BZERO,  0,1,1,1, 2, O_IR|O_PC},
      '{I_BNZERO, 0,0,0,0, 3, O_IR|O_PC|O_BR},
      '{I_BNZERO, 1,0,0,0, 2, O_IR|O_PC},
      '{I_BNEG,   0,1,0,0, 3, O_IR|O_PC|O_BR},
      '{I_BNEG,   1,0,1,1, 2, O_IR|O_PC},
      '{I_BNNEG,  0,0,0,0, 3, O_IR|O_PC|O_BR},
      '{I_BNNEG,  0,1,0,0, 2, O_IR|O_PC},
      '{I_BOV,    0,0,1,0, 3, O_IR|O_PC|O_BR},
      '{I_BOV,    0,0,0,1, 3, O_IR|O_PC|O_BR},
      '{I_BOV,    1,1,0,0, 2, O_IR|O_PC},
      '{I_BNOV,   0,0,0,0, 3, O_IR|O_PC|O_BR},
      '{I_BNOV,   0,0,1,0, 2, O_IR|O_PC},
      '{I_NOP,    1,1,1,1, 2, O_IR|O_PC}
    };
    rst[0] = 1'b0;
    for (int t = 0; t < tbl.size(); t++) begin
      di[0] = tbl[t].in; zf[0] = tbl[t].z; nf[0] = tbl[t].n;
      uo[0] = tbl[t].u; so[0] = tbl[t].s;
      acc = '0;
      for (int c = 0; c < tbl[t].lat; c++) begin
        @(negedge clk);
        if (c == 0) chk($sformatf("tbl%0d_fetch", t), {31'd0, obs(0)[8]}, 1);
        acc |= obs(0);
        @(posedge clk); #1;
      end
      chk($sformatf("tbl%0d_%s", t, tbl[t].in.name()), acc, tbl[t].seen);
    end
    di[0] = I_NOP;
    expn(0, "tbl_end_fetch", O_IR | O_PC);

    // perf counters: 20 NOPs from reset at MEM_WAIT=0
    rst[0] = 1'b1; @(posedge clk); #1; rst[0] = 1'b0; di[0] = I_NOP; run[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 6) chk("nop_mid_cnt", {cyc[0], ins[0]}, PERF ? {4'd6, 4'd3} : 8'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("nop_sat_cnt", {cyc[0], ins[0]}, PERF ? {4'd15, 4'd15} : 8'd0);
    @(posedge clk); #1;
    rst[0] = 1'b1;

    // MEM_WAIT=2 LOAD: next fetch begins on cycle 8
    rst[1] = 1'b0; di[1] = I_LOAD; run[1] = 1'b1;
    expn(1, "ld_f1", 0); expn(1, "ld_f2", 0); expn(1, "ld_f3", O_IR | O_PC);
    expn(1, "ld_dec", 0);
    di[1] = I_NOP;
    expn(1, "ld_w1", O_AS); expn(1, "ld_w2", O_AS); expn(1, "ld_wr", O_AS | O_WR | O_CS);
    expn(1, "ld_nf1", 0); expn(1, "ld_nf2", 0); expn(1, "ld_nf3", O_IR | O_PC);
    expn(1, "nop_dec", 0);

    // run low at the fetch boundary holds; a started fetch ignores run dropping
    run[1] = 1'b0;
    for (int c = 0; c < 5; c++) expn(1, "hold", 0);
    run[1] = 1'b1; expn(1, "rs_f1", 0);
    run[1] = 1'b0; expn(1, "rs_f2", 0); expn(1, "rs_f3", O_IR | O_PC);
    expn(1, "rs_dec", 0);
    expn(1, "hold2", 0); expn(1, "hold3", 0); expn(1, "hold4", 0);

    // HALT: sticky regardless of run, cleared only by reset
    run[1] = 1'b1; di[1] = I_HALT;
    expn(1, "h_f1", 0); expn(1, "h_f2", 0); expn(1, "h_f3", O_IR | O_PC); expn(1, "h_dec", 0);
    for (int c = 0; c < 6; c++) begin
      run[1] = c[0]; di[1] = (c[1]) ? I_ADD : I_LOAD;
      expn(1, "halted", O_HALT);
    end
    rst[1] = 1'b1; expn(1, "h_rst", 0);
    rst[1] = 1'b0; run[1] = 1'b1; di[1] = I_NOP;
    expn(1, "hr_f1", 0); expn(1, "hr_f2", 0); expn(1, "hr_f3", O_IR | O_PC); expn(1, "hr_dec", 0);

    // reset on the LOAD write cycle aborts it and clears the counters
    di[1] = I_LOAD;
    expn(1, "rl_f1", 0); expn(1, "rl_f2", 0); expn(1, "rl_f3", O_IR | O_PC); expn(1, "rl_dec", 0);
    expn(1, "rl_w1", O_AS); expn(1, "rl_w2", O_AS);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("rl_abort", obs(1), 0);
    chk("rl_cnt_rst", {cyc[1], ins[1]}, 0);
    @(posedge clk); #1;
    rst[1] = 1'b0; di[1] = I_NOP;
    @(negedge clk);
    chk("rl_after", obs(1), 0);
    chk("rl_cnt_clr", {cyc[1], ins[1]}, 0);
    @(posedge clk); #1;
    rst[1] = 1'b1;

    rand_phase(0, 0, 3000);
    rand_phase(1, 2, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ks_multicycle_ctrl.md
Name: ks_multicycle_ctrl

Overview:
- Parametrised multi-cycle control FSM for the K&S core; drives datapath enables/selects from the decoded instruction and ALU flags.
- Next generation of the core control unit:
  - configurable memory wait states for fetch and load;
  - full ALU, store, conditional-branch and halt sequencing;
  - a run/pause input;
  - optional performance counters.
- Sits between the decoder and the datapath/RAM interface.

Parameters:
- MEM_WAIT, 0, extra RAM access cycles per fetch/load (0..15).
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- run  input  1  1 = allow new fetch; 0 = pause at fetch boundary
- decoded_instruction  input  decoded_instruction_type (k_and_s_pkg)  current decoded instruction
- zero_op, neg_op, unsigned_overflow, signed_overflow  input  1 each  registered ALU flags
- branch  output  1  PC loads branch target
- pc_enable  output  1  PC update
- ir_enable  output  1  IR load
- write_reg_enable  output  1  register file write
- addr_sel  output  1  0 = PC address, 1 = IR operand address
- c_sel  output  1  0 = ALU result, 1 = RAM data to register file
- operation  output  2  00 OR, 01 ADD, 10 SUB, 11 AND
- flags_reg_enable  output  1  flag register update
- ram_write_enable  output  1  RAM write strobe
- halt  output  1  core halted
- cycle_count  output  CNT_W  performance counter (see Optional Feature)
- instr_count  output  CNT_W  performance counter (see Optional Feature)

Behaviour:
- Reset:
  - On a clk edge with rst=1: state=FETCH, wait counter=0, counters=0.
  - All outputs 0 while rst=1.
  - Reset mid-operation aborts the instruction; no write, store or branch completes in that cycle.
- Outputs: decoded from state plus wait counter. decoded_instruction and flags are sampled only in DECODE. Every output not listed for a state is 0.
- FETCH:
  - addr_sel=0.
  - Counter 0 with run=0: hold, all enables 0.
  - Otherwise count 0..MEM_WAIT. At count==MEM_WAIT: ir_enable=1, pc_enable=1, counter clears, go to DECODE.
  - run is checked only at counter 0; a started fetch completes even if run drops.
- DECODE (1 cycle, no enables):
  - ADD/SUB/AND/OR/MOVE -> EXEC_ALU.
  - LOAD -> LOAD.
  - STORE -> STORE.
  - HALT -> HALTED.
  - BRANCH -> BRANCH.
  - Conditional branches: BZERO (zero_op=1), BNZERO (zero_op=0), BNEG (neg_op=1), BNNEG (neg_op=0), BOV (signed_overflow|unsigned_overflow =1), BNOV (both 0). Condition true -> BRANCH, false -> FETCH.
  - NOP and unrecognised encodings -> FETCH.
- EXEC_ALU (1 cycle):
  - write_reg_enable=1, c_sel=0, operation per opcode.
  - flags_reg_enable=1 for ADD/SUB/AND/OR; 0 for MOVE, which uses operation=00 (datapath passes operand).
  - -> FETCH.
- LOAD:
  - addr_sel=1 throughout; counter 0..MEM_WAIT.
  - At count==MEM_WAIT: write_reg_enable=1, c_sel=1, -> FETCH.
- STORE (1 cycle): addr_sel=1, ram_write_enable=1, -> FETCH.
- BRANCH (1 cycle): branch=1, pc_enable=1, -> FETCH.
- HALTED: halt=1 continuously; no other output ever asserted; exit only via rst. run is ignored.
- Latencies (MEM_WAIT=W), first FETCH cycle to next FETCH:
  - ALU: 3+W
  - LOAD: 3+2W
  - STORE: 3+W
  - taken branch: 3+W
  - not-taken branch / NOP: 2+W
- Invariants:
  - At most one of write_reg_enable, ram_write_enable, ir_enable is high per cycle.
  - Wait counter never exceeds MEM_WAIT.
  - With MEM_WAIT=0 the counter is constant 0.

Optional Feature:
- Macro KS_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_count increments every cycle with rst=0 and state!=HALTED.
  - instr_count increments on every cycle with ir_enable=1.
  - Both saturate at all-ones, never wrap, and clear on rst.
- Undefined: cycle_count and instr_count are tied to 0; no counter flops exist.

Test Plan:
- MEM_WAIT=0, run=1, ADD after reset -> ir_enable+pc_enable in cycle 1, DECODE cycle 2, cycle 3 write_reg_enable=1, operation=01, flags_reg_enable=1.
- MEM_WAIT=2, LOAD -> ir_enable only in fetch cycle 3; addr_sel=1 for 3 LOAD cycles; write_reg_enable+c_sel=1 only on the 3rd; next fetch starts at cycle 8.
- BZERO with zero_op=1 -> BRANCH cycle with branch=1, pc_enable=1. BZERO with zero_op=0 -> DECODE then FETCH, branch never 1. Repeat for BNEG/BOV pairs.
- run=0 at fetch boundary for 5 cycles -> all enables 0, state FETCH. run=1 -> fetch proceeds. run dropped mid-fetch (MEM_WAIT=3) -> fetch still completes.
- HALT then run toggling -> halt=1 held indefinitely, all other outputs 0. rst=1 for one edge -> halt=0, FETCH.
- KS_CTRL_PERF_CNT_EN, CNT_W=4, 20 NOPs at MEM_WAIT=0 -> instr_count saturates at 15, cycle_count at 15. rst mid-LOAD -> no write_reg_enable, counters 0.
